// File: rtl/ks_pkg.sv
// ks_pkg
// Shared definitions for the keystream XOR cipher slice.
//   - ser_state_e       : serialiser states (EMPTY, LOAD, ACTIVE)
//   - KS_BYTES_PER_WORD : keystream bytes consumed from each 32-bit word
//   - KS_IDX_W          : width of the byte index inside a word
//   - KS_LAST_IDX       : byte index of the final byte taken from a word
// Optional build macro: KS_MANTISSA_EN. When defined, only the three mantissa
// bytes (bits 23:0) of each word are used.
package ks_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        ACTIVE
    } ser_state_e;

`ifdef KS_MANTISSA_EN
    // The sign/exponent byte of the floating-point map output carries little
    // entropy, so it is skipped.
    localparam int KS_BYTES_PER_WORD = 3;
`else
    localparam int KS_BYTES_PER_WORD = 4;
`endif

    localparam int KS_IDX_W = 2;

    localparam logic [KS_IDX_W-1:0] KS_LAST_IDX = KS_IDX_W'(KS_BYTES_PER_WORD - 1);

endpackage

// File: rtl/ks_fifo.sv
// ks_fifo
// Circular buffer of 32-bit keystream words with a registered read port.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   push       : write wdata when not full (a push while full is ignored)
//   pop        : load the head word into rdata on the next edge
//   wdata      : word to write
//   rdata      : registered head word, valid the cycle after pop
//   level      : number of words held
//   full       : level == DEPTH
module ks_fifo #(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [LVL_W-1:0] level,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             wr_en;
    logic             rd_en;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign wr_en = push & ~full;
    assign rd_en = pop & (level_q != '0);

    // DEPTH is a power of two, so plain increment wraps the pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rdata_d  = rdata_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            rdata_d  = mem_q[rd_ptr_q];
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage needs no reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = rdata_q;
    assign level = level_q;

endmodule

// File: rtl/ks_xor_cipher.sv
// ks_xor_cipher
// Captures keystream words from the chaotic map generator (one per rising
// edge of ks_strobe) into a FIFO, serialises each word LSB byte first and
// XORs the bytes onto a valid/ready plaintext stream.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ks_data, ks_strobe  : keystream word and its level strobe
//   pt_data/valid/ready : plaintext byte input handshake
//   ct_data/valid/ready : ciphertext byte output handshake
//   ks_level            : words held in the FIFO
//   ks_overflow         : sticky, a keystream word was dropped (FIFO full)
// Optional build macro: KS_MANTISSA_EN (3 bytes per word instead of 4).
module ks_xor_cipher
    import ks_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ks_data,
    input  logic             ks_strobe,
    input  logic [7:0]       pt_data,
    input  logic             pt_valid,
    output logic             pt_ready,
    output logic [7:0]       ct_data,
    output logic             ct_valid,
    input  logic             ct_ready,
    output logic [LVL_W-1:0] ks_level,
    output logic             ks_overflow
);

    ser_state_e          state_q, state_d;
    logic                strobe_q, strobe_d;
    logic                overflow_q, overflow_d;
    logic [KS_IDX_W-1:0] idx_q, idx_d;
    logic [31:0]         cur_word_q, cur_word_d;
    logic [7:0]          ct_data_q, ct_data_d;
    logic                ct_valid_q, ct_valid_d;

    logic                push;
    logic                pop;
    logic                accept;
    logic                fifo_full;
    logic [31:0]         fifo_rdata;
    logic [7:0]          ks_byte;

    // The strobe is a level from a multi-cycle iteration, so only its rising
    // edge counts; strobe_q resets to 0 so a strobe already high at reset
    // release is taken as an edge.
    assign push = ks_strobe & ~strobe_q;

    ks_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (ks_data),
        .rdata (fifo_rdata),
        .level (ks_level),
        .full  (fifo_full)
    );

    // Serialiser state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Serialiser next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (ks_level != '0) state_d = LOAD;
            LOAD:    state_d = ACTIVE;
            ACTIVE:  if (accept && (idx_q == KS_LAST_IDX)) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Serialiser outputs. A byte may be taken whenever the output register is
    // empty or is being drained this cycle.
    always_comb begin
        pop      = 1'b0;
        pt_ready = 1'b0;
        case (state_q)
            EMPTY:   pop      = (ks_level != '0);
            ACTIVE:  pt_ready = ~ct_valid_q | ct_ready;
            default: ;
        endcase
    end

    assign accept  = pt_valid & pt_ready;
    assign ks_byte = cur_word_q[{idx_q, 3'b000} +: 8];

    // Datapath: word latch, byte index, ciphertext register and sticky
    // overflow. The overflow test uses the full flag before any same-cycle pop.
    always_comb begin
        strobe_d   = ks_strobe;
        overflow_d = overflow_q | (push & fifo_full);
        idx_d      = idx_q;
        cur_word_d = cur_word_q;
        ct_data_d  = ct_data_q;
        ct_valid_d = ct_valid_q;
        if (state_q == LOAD) begin
            cur_word_d = fifo_rdata;
            idx_d      = '0;
        end
        if (accept) begin
            ct_data_d  = pt_data ^ ks_byte;
            ct_valid_d = 1'b1;
            idx_d      = idx_q + KS_IDX_W'(1);
        end else if (ct_ready) begin
            ct_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_q   <= 1'b0;
            overflow_q <= 1'b0;
            idx_q      <= '0;
            cur_word_q <= '0;
            ct_data_q  <= '0;
            ct_valid_q <= 1'b0;
        end else begin
            strobe_q   <= strobe_d;
            overflow_q <= overflow_d;
            idx_q      <= idx_d;
            cur_word_q <= cur_word_d;
            ct_data_q  <= ct_data_d;
            ct_valid_q <= ct_valid_d;
        end
    end

    assign ct_data     = ct_data_q;
    assign ct_valid    = ct_valid_q;
    assign ks_overflow = overflow_q;

endmodule

// File: tb/tb_ks_xor_cipher.sv
// tb_ks_xor_cipher
// Directed bench for ks_xor_cipher: reset values, single word, word boundary
// bubble, held strobe with output backpressure, FIFO overflow and reset in
// the middle of a word. Honours KS_MANTISSA_EN (3 bytes per word).
module tb_ks_xor_cipher;

`ifdef KS_MANTISSA_EN
    localparam int BPW = 3;
`else
    localparam int BPW = 4;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] ks_data;
    logic        ks_strobe;
    logic [7:0]  pt_data;
    logic        pt_valid;
    logic        pt_ready;
    logic [7:0]  ct_data;
    logic        ct_valid;
    logic        ct_ready;
    logic [2:0]  ks_level;
    logic        ks_overflow;

    int compared   = 0;
    int mismatched = 0;

    ks_xor_cipher #(
        .DEPTH (4),
        .LVL_W (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ks_data     (ks_data),
        .ks_strobe   (ks_strobe),
        .pt_data     (pt_data),
        .pt_valid    (pt_valid),
        .pt_ready    (pt_ready),
        .ct_data     (ct_data),
        .ct_valid    (ct_valid),
        .ct_ready    (ct_ready),
        .ks_level    (ks_level),
        .ks_overflow (ks_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One strobe pulse: high for a cycle, then low for a cycle.
    task automatic push_word(input logic [31:0] w);
        ks_data   = w;
        ks_strobe = 1'b1;
        tick();
        ks_strobe = 1'b0;
        tick();
    endtask

    // Offer one plaintext byte, wait (bounded) for acceptance, then check the
    // ciphertext register one cycle later. pt_valid is left high.
    task automatic send_byte(input logic [7:0] pt, input logic [7:0] exp, input string tag);
        int waited = 0;
        pt_valid = 1'b1;
        pt_data  = pt;
        #1;
        while (!pt_ready && waited < 20) begin
            tick();
            waited++;
        end
        check_output({tag, "_ready"}, 32'(pt_ready), 32'd1);
        tick();
        check_output({tag, "_ctv"}, 32'(ct_valid), 32'd1);
        check_output({tag, "_ctd"}, 32'(ct_data), 32'(exp));
    endtask

    logic [7:0]  exp1 [4];
    logic [7:0]  exp2a [4];
    logic [31:0] ovw [6];
    logic [31:0] w;

    initial begin
        exp1  = '{8'h11, 8'h0F, 8'hC3, 8'hA5};
        exp2a = '{8'h51, 8'h56, 8'h57, 8'h54};
        ovw   = '{32'hDEADBEEF, 32'h13579BDF, 32'h2468ACE0,
                  32'h0F1E2D3C, 32'h89ABCDEF, 32'h55AA55AA};

        reset     = 1'b1;
        ks_data   = '0;
        ks_strobe = 1'b0;
        pt_data   = '0;
        pt_valid  = 1'b0;
        ct_ready  = 1'b1;
        tick();
        tick();
        check_output("rst_pt_ready", 32'(pt_ready), 32'd0);
        check_output("rst_ct_valid", 32'(ct_valid), 32'd0);
        check_output("rst_ct_data", 32'(ct_data), 32'd0);
        check_output("rst_level", 32'(ks_level), 32'd0);
        check_output("rst_overflow", 32'(ks_overflow), 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] basic word");
        ks_data   = 32'hA5C30F11;
        ks_strobe = 1'b1;
        tick();
        ks_strobe = 1'b0;
        check_output("basic_level", 32'(ks_level), 32'd1);
        for (int i = 0; i < BPW; i++) send_byte(8'h00, exp1[i], $sformatf("basic_b%0d", i));
        check_output("basic_ready_drop", 32'(pt_ready), 32'd0);
        pt_valid = 1'b0;
        tick();
        tick();
        tick();
        check_output("basic_stays_empty", 32'(pt_ready), 32'd0);

        $display("[TB] word boundary");
        push_word(32'h01020304);
        tick();
        ks_data   = 32'hFFFFFFFF;
        ks_strobe = 1'b1;
        tick();
        ks_strobe = 1'b0;
        check_output("wb_level_queued", 32'(ks_level), 32'd1);
        for (int i = 0; i < BPW; i++) send_byte(8'h55, exp2a[i], $sformatf("wbA_b%0d", i));
        check_output("wb_bubble1_ready", 32'(pt_ready), 32'd0);
        check_output("wb_bubble1_level", 32'(ks_level), 32'd1);
        tick();
        check_output("wb_bubble2_ready", 32'(pt_ready), 32'd0);
        check_output("wb_bubble2_level", 32'(ks_level), 32'd0);
        check_output("wb_bubble2_ctv", 32'(ct_valid), 32'd0);
        tick();
        check_output("wb_after_bubble", 32'(pt_ready), 32'd1);
        for (int i = 0; i < BPW; i++) send_byte(8'h55, 8'hAA, $sformatf("wbB_b%0d", i));
        pt_valid = 1'b0;

        $display("[TB] held strobe and backpressure");
        ks_data   = 32'h11223344;
        ks_strobe = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 4) ks_data = 32'h99999999;
        end
        ks_strobe = 1'b0;
        check_output("hold_level", 32'(ks_level), 32'd0);
        send_byte(8'h00, 8'h44, "bp_b0");
        ct_ready = 1'b0;
        pt_data  = 8'hFF;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("bp_stall%0d_ready", i), 32'(pt_ready), 32'd0);
            check_output($sformatf("bp_stall%0d_ctv", i), 32'(ct_valid), 32'd1);
            check_output($sformatf("bp_stall%0d_ctd", i), 32'(ct_data), 32'h44);
            tick();
        end
        ct_ready = 1'b1;
        send_byte(8'hFF, 8'hCC, "bp_b1");
        send_byte(8'h00, 8'h22, "bp_b2");
        if (BPW == 4) send_byte(8'h00, 8'h11, "bp_b3");
        pt_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_output("hold_one_word_ready", 32'(pt_ready), 32'd0);
        check_output("hold_one_word_level", 32'(ks_level), 32'd0);

        $display("[TB] overflow");
        for (int k = 0; k < 5; k++) push_word(ovw[k]);
        check_output("ovf_level_full", 32'(ks_level), 32'd4);
        check_output("ovf_not_yet", 32'(ks_overflow), 32'd0);
        push_word(ovw[5]);
        check_output("ovf_level_after", 32'(ks_level), 32'd4);
        check_output("ovf_set", 32'(ks_overflow), 32'd1);
        for (int k = 0; k < 5; k++) begin
            w = ovw[k];
            for (int i = 0; i < BPW; i++) send_byte(8'h00, w[8*i +: 8], $sformatf("ovf_w%0d_b%0d", k, i));
        end
        pt_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_output("ovf_drained_ready", 32'(pt_ready), 32'd0);
        check_output("ovf_drained_level", 32'(ks_level), 32'd0);
        check_output("ovf_sticky", 32'(ks_overflow), 32'd1);

        $display("[TB] reset mid-word");
        push_word(32'hCAFEBABE);
        push_word(32'h12345678);
        send_byte(8'h00, 8'hBE, "rm_b0");
        send_byte(8'h00, 8'hBA, "rm_b1");
        pt_valid  = 1'b0;
        ct_ready  = 1'b0;
        reset     = 1'b1;
        ks_data   = 32'h0A0B0C0D;
        ks_strobe = 1'b1;
        tick();
        check_output("rm_ct_valid", 32'(ct_valid), 32'd0);
        check_output("rm_ct_data", 32'(ct_data), 32'd0);
        check_output("rm_level", 32'(ks_level), 32'd0);
        check_output("rm_overflow", 32'(ks_overflow), 32'd0);
        check_output("rm_pt_ready", 32'(pt_ready), 32'd0);
        reset    = 1'b0;
        ct_ready = 1'b1;
        tick();
        ks_strobe = 1'b0;
        check_output("rm_strobe_at_release", 32'(ks_level), 32'd1);
        send_byte(8'h00, 8'h0D, "rm_new_b0");
        send_byte(8'h00, 8'h0C, "rm_new_b1");
        send_byte(8'h00, 8'h0B, "rm_new_b2");
        if (BPW == 4) send_byte(8'h00, 8'h0A, "rm_new_b3");
        check_output("rm_end_ready", 32'(pt_ready), 32'd0);
        pt_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
